clkdiv_multi: RTL

- Multi-channel programmable clock divider and tick generator. Generalises the single-channel toggle divider to NCH independent channels.
- Each channel has its own limit, mode (50% square or one-cycle pulse) and enable. Limit/mode changes are glitch-free, applied only at period boundaries.
- A global sync realigns all channels.
- Feeds tempo, step-sequencer and voice-rate timing in the drum machine. Everything runs in the single system clock domain.

---
 rtl/clkdiv_pkg.sv | 17 +
 rtl/clkdiv_multi_if.sv | 24 ++
 rtl/clkdiv_chan.sv | 91 +++++++++
 rtl/clkdiv_multi.sv | 28 ++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// Shared types and default sizing for the multi-channel clock divider.
package clkdiv_pkg;

  localparam int unsigned CD_BITLEN = 8;
  localparam int unsigned CD_NCH    = 4;

  typedef enum logic {
    CD_TOGGLE = 1'b0,
    CD_PULSE  = 1'b1
  } cd_mode_t;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_t;

endpackage : clkdiv_pkg

// File: rtl/clkdiv_multi_if.sv
// Control/output bundle of the multi-channel divider; master drives controls, slave returns hz/tick.
interface clkdiv_multi_if #(
  parameter int unsigned NCH    = 4,
  parameter int unsigned BITLEN = 8
);

  logic [NCH-1:0]        en;
  logic                  sync;
  logic [NCH*BITLEN-1:0] lim;
  logic [NCH-1:0]        mode;
  logic [NCH-1:0]        hz;
  logic [NCH-1:0]        tick;

  modport master (
    output en, sync, lim, mode,
    input  hz, tick
  );

  modport slave (
    input  en, sync, lim, mode,
    output hz, tick
  );

endinterface : clkdiv_multi_if

// File: rtl/clkdiv_chan.sv
// One divider channel: counter, shadow limit/mode applied at period boundaries, registered hz/tick.
module clkdiv_chan
  import clkdiv_pkg::*;
#(
  parameter int unsigned BITLEN = CD_BITLEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sync,
  input  logic [BITLEN-1:0] lim,
  input  cd_mode_t          mode,
  output logic              hz,
  output logic              tick
);

  ch_state_t         state_q, state_d;
  logic [BITLEN-1:0] cnt_q, cnt_d;
  logic [BITLEN-1:0] act_lim_q, act_lim_d;
  cd_mode_t          act_mode_q, act_mode_d;
  logic              hz_q, hz_d;
  logic              tick_q, tick_d;
  logic              load;
  logic              wrap;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= CH_IDLE;
      cnt_q      <= '0;
      act_lim_q  <= '0;
      act_mode_q <= CD_TOGGLE;
      hz_q       <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      act_lim_q  <= act_lim_d;
      act_mode_q <= act_mode_d;
      hz_q       <= hz_d;
      tick_q     <= tick_d;
    end
  end

  // Next state: run while enabled, re-enable always passes through LOAD from IDLE
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = CH_IDLE;
    end else begin
      state_d = CH_RUN;
    end
  end

  // Counter, shadow reload and outputs; sync beats a coincident wrap
  always_comb begin
    cnt_d      = cnt_q;
    act_lim_d  = act_lim_q;
    act_mode_d = act_mode_q;
    hz_d       = hz_q;
    tick_d     = 1'b0;
    load       = en && ((state_q == CH_IDLE) || sync);
    wrap       = en && !load && (cnt_q == act_lim_q);

    if (!en) begin
      cnt_d = '0;
      hz_d  = 1'b0;
    end else if (load) begin
      cnt_d      = '0;
      act_lim_d  = lim;
      act_mode_d = mode;
      hz_d       = 1'b0;
    end else if (wrap) begin
      cnt_d      = '0;
      tick_d     = 1'b1;
      act_lim_d  = lim;
      act_mode_d = mode;
      // The incoming mode governs hz from this wrap edge onward
      hz_d       = (mode == CD_PULSE) ? 1'b1 : ~hz_q;
    end else begin
      cnt_d = cnt_q + BITLEN'(1);
      if (act_mode_q == CD_PULSE) begin
        hz_d = 1'b0;
      end
    end
  end

  assign hz   = hz_q;
  assign tick = tick_q;

endmodule : clkdiv_chan

// File: rtl/clkdiv_multi.sv
// NCH independent programmable divider channels sharing a single realign strobe.
module clkdiv_multi
  import clkdiv_pkg::*;
#(
  parameter int unsigned BITLEN = CD_BITLEN,
  parameter int unsigned NCH    = CD_NCH
) (
  input logic           clk,
  input logic           rst,
  clkdiv_multi_if.slave bus
);

  for (genvar i = 0; i < int'(NCH); i++) begin : g_ch
    clkdiv_chan #(
      .BITLEN (BITLEN)
    ) u_chan (
      .clk  (clk),
      .rst  (rst),
      .en   (bus.en[i]),
      .sync (bus.sync),
      .lim  (bus.lim[i*BITLEN +: BITLEN]),
      .mode (cd_mode_t'(bus.mode[i])),
      .hz   (bus.hz[i]),
      .tick (bus.tick[i])
    );
  end

endmodule : clkdiv_multi
